// File: rtl/bram_sdp_pkg.sv
// bram_sdp_pkg
//   Shared constants and helpers for the split simple-dual-port RAM family.
//   - RDW_READ_FIRST / RDW_WRITE_FIRST : read-during-write collision modes
//   - nbe()       : number of byte lanes for a given data/lane width
//   - lane_mask() : expands a lane-enable vector into a per-bit write mask
package bram_sdp_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  // Upper bounds for the helper below; index math is kept at 8 bits.
  localparam int MAX_DWIDTH = 256;
  localparam int MAX_NBE    = 256;

  // Ceiling division; a non-positive lane width is reported by the elaboration
  // checks, so return 1 here just to keep the port widths legal.
  function automatic int nbe(input int dwidth, input int be_width);
    if (be_width < 1) return 1;
    return (dwidth + be_width - 1) / be_width;
  endfunction

  // Bit i of the result follows lane i/be_width; bits at or above dwidth stay 0,
  // which is how a partial top lane gets truncated.
  function automatic logic [MAX_DWIDTH-1:0] lane_mask(input int dwidth,
                                                      input int be_width,
                                                      input logic [MAX_NBE-1:0] be);
    logic [MAX_DWIDTH-1:0] m;
    int lane;
    m = '0;
    if (be_width > 0) begin
      for (int i = 0; i < MAX_DWIDTH; i++) begin
        if (i < dwidth) begin
          lane = i / be_width;
          m[i[7:0]] = be[lane[7:0]];
        end
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/bram_sdp_chan.sv
// bram_sdp_chan
//   One simple-dual-port memory channel: byte-lane writes, selectable
//   read-during-write behaviour and an optional second output register.
//   Ports:
//     clk, rst          : clock, synchronous active-high reset
//     rce, ra           : read enable / read address
//     rq, rvalid        : read data / read data valid
//     wce, wa, wd, wbe  : write enable / address / data / lane enables
module bram_sdp_chan
  import bram_sdp_pkg::*;
#(
  parameter int AWIDTH   = 10,
  parameter int DWIDTH   = 18,
  parameter int BE_WIDTH = 9,
  parameter int OREG     = 0,
  parameter int RDW_MODE = RDW_READ_FIRST,
  localparam int NBE     = nbe(DWIDTH, BE_WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rce,
  input  logic [AWIDTH-1:0] ra,
  output logic [DWIDTH-1:0] rq,
  output logic              rvalid,
  input  logic              wce,
  input  logic [AWIDTH-1:0] wa,
  input  logic [DWIDTH-1:0] wd,
  input  logic [NBE-1:0]    wbe
);

  if (BE_WIDTH < 1) begin : g_bad_be
    $error("bram_sdp_chan: BE_WIDTH must be at least 1");
  end
  if (DWIDTH > MAX_DWIDTH) begin : g_bad_dw
    $error("bram_sdp_chan: DWIDTH exceeds MAX_DWIDTH");
  end

  logic [DWIDTH-1:0] mem [1<<AWIDTH];

  logic [DWIDTH-1:0] mask;
  logic [DWIDTH-1:0] old_data;
  logic [DWIDTH-1:0] merged;
  logic [DWIDTH-1:0] rd_data;
  logic              collision;
  logic [DWIDTH-1:0] q1;
  logic              v1;

  assign mask      = DWIDTH'(lane_mask(DWIDTH, BE_WIDTH, MAX_NBE'(wbe)));
  assign old_data  = mem[ra];
  assign merged    = (old_data & ~mask) | (wd & mask);
  assign collision = wce && (ra == wa);

  // Write-first forwards the lane merge only on an address match; otherwise
  // the array value read this cycle is the pre-write content.
  assign rd_data = ((RDW_MODE == RDW_WRITE_FIRST) && collision) ? merged : old_data;

  // Memory contents are deliberately not reset, only protected during reset.
  always_ff @(posedge clk) begin
    if (!rst && wce) begin
      mem[wa] <= (mem[wa] & ~mask) | (wd & mask);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q1 <= '0;
      v1 <= 1'b0;
    end else begin
      v1 <= rce;
      if (rce) q1 <= rd_data;
    end
  end

  if (OREG != 0) begin : g_oreg
    logic [DWIDTH-1:0] q2;
    logic              v2;

    // Second stage only captures real reads so rq keeps the last result.
    always_ff @(posedge clk) begin
      if (rst) begin
        q2 <= '0;
        v2 <= 1'b0;
      end else begin
        v2 <= v1;
        if (v1) q2 <= q1;
      end
    end

    assign rq     = q2;
    assign rvalid = v2;
  end else begin : g_noreg
    assign rq     = q1;
    assign rvalid = v1;
  end

endmodule

// File: rtl/bram_sdp_split_multi.sv
// bram_sdp_split_multi
//   NCH independent simple-dual-port memories on one clock. Only slices the
//   packed port vectors into per-channel bram_sdp_chan instances.
//   Ports:
//     clk, rst     : clock, synchronous active-high reset
//     rce, ra      : per-channel read enable / packed read addresses
//     rq, rvalid   : packed read data / per-channel valid
//     wce, wa, wd  : per-channel write enable / packed addresses / data
//     wbe          : packed lane enables, NBE per channel
module bram_sdp_split_multi
  import bram_sdp_pkg::*;
#(
  parameter int NCH      = 2,
  parameter int AWIDTH   = 10,
  parameter int DWIDTH   = 18,
  parameter int BE_WIDTH = 9,
  parameter int OREG     = 0,
  parameter int RDW_MODE = RDW_READ_FIRST,
  localparam int NBE     = nbe(DWIDTH, BE_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        rce,
  input  logic [NCH*AWIDTH-1:0] ra,
  output logic [NCH*DWIDTH-1:0] rq,
  output logic [NCH-1:0]        rvalid,
  input  logic [NCH-1:0]        wce,
  input  logic [NCH*AWIDTH-1:0] wa,
  input  logic [NCH*DWIDTH-1:0] wd,
  input  logic [NCH*NBE-1:0]    wbe
);

  if (NCH < 1 || NCH > 4) begin : g_bad_nch
    $error("bram_sdp_split_multi: NCH must be in 1..4");
  end
  if (BE_WIDTH < 1) begin : g_bad_be
    $error("bram_sdp_split_multi: BE_WIDTH must be at least 1");
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    bram_sdp_chan #(
      .AWIDTH   (AWIDTH),
      .DWIDTH   (DWIDTH),
      .BE_WIDTH (BE_WIDTH),
      .OREG     (OREG),
      .RDW_MODE (RDW_MODE)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .rce    (rce[c]),
      .ra     (ra[c*AWIDTH +: AWIDTH]),
      .rq     (rq[c*DWIDTH +: DWIDTH]),
      .rvalid (rvalid[c]),
      .wce    (wce[c]),
      .wa     (wa[c*AWIDTH +: AWIDTH]),
      .wd     (wd[c*DWIDTH +: DWIDTH]),
      .wbe    (wbe[c*NBE +: NBE])
    );
  end

endmodule
